spu_arf_key_seq: RTL and testbench
==================================

Name: spu_arf_key_seq

Overview:
- Control stage directly upstream of the SPU AES key register file (16 entries x 128 bits, 1R1W, 64-bit half-writes, no write bypass).
- Accepts expanded AES round keys from the key-expansion unit as 64-bit beats over a valid/ready handshake. Packs them into entries as low/high halves and drives the array write port.
- On a cipher start, sequences the read port through the round keys in forward (encrypt) or reverse (decrypt) order.
- Guarantees the array never sees a same-address read/write collision.

Parameters:
- NENT, 16, number of key-file entries.
- RD_LAT, 1, cycles from rd_enable issue to array data valid.

Ports:
- l2clk  in  1  block clock
- rst_l  in  1  asynchronous active-low reset
- key_len  in  2  00=AES-128, 01=AES-192, 10=AES-256, 11=reserved; sampled at ld_start/rk_start
- ld_start  in  1  pulse: begin a key load at entry 0
- ld_valid  in  1  key beat valid
- ld_data  in  64  key beat
- ld_last  in  1  final beat of the load
- ld_ready  out  1  beat accepted when ld_valid & ld_ready
- rk_start  in  1  pulse: begin round-key readout
- rk_dec  in  1  1=reverse order (decrypt); sampled with rk_start
- rk_valid  out  1  arf_rd_data carries round key rk_idx this cycle
- rk_idx  out  4  round number of the current key
- rk_done  out  1  one-cycle pulse with the last rk_valid
- wr_addr  out  4  array write address
- wr_data  out  64  array write data
- wr_enable  out  2  [0]=low half, [1]=high half
- rd_addr  out  4  array read address
- rd_enable  out  1  array read enable
- busy  out  1  FSM not IDLE
- seq_err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_l=0): FSM=IDLE; all outputs 0 (ld_ready=0, wr_enable=00, rd_enable=0, rk_valid=0, seq_err=0); beat/entry counters 0.
- Nr: 10/12/14 for key_len 00/01/10. Entries used = Nr+1. Beats = 2*(Nr+1) = 22/26/30.
- States: IDLE, LOAD, READ, DRAIN.
- IDLE:
  - ld_start -> LOAD. Clear beat_cnt; latch key_len.
  - rk_start -> READ. Latch key_len and rk_dec.
  - Both asserted in the same cycle: ld_start wins and seq_err is set.
  - key_len=11 at start: no transition, seq_err set.
- LOAD:
  - ld_ready=1.
  - Each accepted beat drives wr_data=ld_data, wr_addr=beat_cnt[4:1], wr_enable=(beat_cnt[0] ? 10 : 01) in the same cycle (combinational from the handshake). beat_cnt then increments.
  - ld_last accepted -> IDLE.
  - If ld_last arrives with beat_cnt+1 != beats, or beat_cnt reaches beats without ld_last, set seq_err. In the second case, force -> IDLE and drop further beats.
  - rk_start is ignored during LOAD.
- READ:
  - Issue one rd_enable per cycle. rd_addr counts 0..Nr (encrypt) or Nr..0 (decrypt).
  - After the final issue -> DRAIN.
  - Never write and read in the same cycle: ld_ready=0 in READ/DRAIN.
- DRAIN: wait RD_LAT cycles -> IDLE.
- rk_valid/rk_idx: rd_enable and rd_addr delayed by RD_LAT through a pipe. rk_idx is the round number: rd_addr for encrypt, Nr-rd_addr for decrypt.
- rk_done: coincides with the last rk_valid.
- ld_start or rk_start while busy: ignored; seq_err set.
- Reset mid-LOAD: partial entries remain in the array and are considered invalid; no cleanup.
- seq_err clears only on reset.

Optional Feature:
- Macro: SPU_ARF_KEY_PARITY_EN.
- Defined:
  - One even-parity bit per 64-bit beat is stored in an internal 2xNENT flop array.
  - Output port par_err (1 bit) is added. It asserts with rk_valid when recomputed parity over arf_rd_data (input port arf_rd_data[127:0], present only with this macro) mismatches either stored half.
- Undefined: no parity flops, no par_err port, no arf_rd_data input.

Decomposition:
- Package spu_arf_pkg: key_len encodings, Nr table, state enum (IDLE/LOAD/READ/DRAIN), NENT.
- One sub-module, spu_arf_rd_pipe: the RD_LAT delay line for rd_enable/rk_idx/last flag.

Test Plan:
- AES-128 load, 22 beats with ld_last on beat 22 -> 22 writes: entry 0 low, 0 high ... entry 10 high; seq_err=0; busy falls the cycle after the last beat.
- AES-256 encrypt readout after load -> rd_addr 0..14 on consecutive cycles; rk_valid 15 cycles starting RD_LAT later; rk_done with rk_idx=14.
- AES-192 decrypt -> rd_addr 12..0; rk_idx 0..12; rk_done with rk_idx=12.
- ld_last on beat 20 of AES-128 -> seq_err=1; FSM returns to IDLE.
- ld_start and rk_start in the same IDLE cycle -> LOAD entered; seq_err=1; no rd_enable asserted.
- rst_l low mid-LOAD (beat 7) -> all outputs 0 immediately; a subsequent clean load works.

Source files
------------

// File: rtl/spu_arf_pkg.sv
// Shared encodings for the SPU AES key-file sequencer: key lengths, round counts,
// FSM state constants and the key-file depth.
package spu_arf_pkg;

    localparam int NENT = 16;

    localparam logic [1:0] KL_128 = 2'b00;
    localparam logic [1:0] KL_192 = 2'b01;
    localparam logic [1:0] KL_256 = 2'b10;
    localparam logic [1:0] KL_RSV = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_READ  = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

    // Number of AES rounds; the reserved encoding maps to 0 and is never latched.
    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            KL_128:  return 4'd10;
            KL_192:  return 4'd12;
            KL_256:  return 4'd14;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/spu_arf_key_seq_rd_pipe.sv
// Read-latency delay line: carries the read-issue valid and its payload
// (round index, last flag, optional parity) to line up with array read data.
module spu_arf_rd_pipe #(
    parameter int RD_LAT = 1,
    parameter int PW     = 5
) (
    input  logic          i_clk,
    input  logic          i_rst_l,
    input  logic          i_valid,
    input  logic [PW-1:0] i_data,
    output logic          o_valid,
    output logic [PW-1:0] o_data
);

    logic [RD_LAT-1:0] r_vld;
    logic [PW-1:0]     r_dat [RD_LAT];

    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            r_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) r_dat[i] <= '0;
        end else begin
            r_vld[0] <= i_valid;
            r_dat[0] <= i_data;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    assign o_valid = r_vld[RD_LAT-1];
    assign o_data  = r_dat[RD_LAT-1];

endmodule

// File: rtl/spu_arf_key_seq.sv
// AES round-key file sequencer: packs 64-bit key beats into the key array and
// sequences round-key readout. Optional parity checking under SPU_ARF_KEY_PARITY_EN.
module spu_arf_key_seq
    import spu_arf_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic          l2clk,
    input  logic          rst_l,
    input  logic [1:0]    key_len,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [63:0]   ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic          rk_start,
    input  logic          rk_dec,
    output logic          rk_valid,
    output logic [3:0]    rk_idx,
    output logic          rk_done,
    output logic [3:0]    wr_addr,
    output logic [63:0]   wr_data,
    output logic [1:0]    wr_enable,
    output logic [3:0]    rd_addr,
    output logic          rd_enable,
    output logic          busy,
    output logic          seq_err,
`ifdef SPU_ARF_KEY_PARITY_EN
    input  logic [127:0]  arf_rd_data,
    output logic          par_err,
`endif
    output logic [1:0]    dbg_state
);

`ifdef SPU_ARF_KEY_PARITY_EN
    localparam int PW = 7;
`else
    localparam int PW = 5;
`endif
    localparam logic [3:0] DRAIN_LAST = 4'(RD_LAT - 1);

    state_t      r_state;
    logic [4:0]  r_beat_cnt;
    logic [1:0]  r_kl;
    logic        r_dec;
    logic [3:0]  r_rd_cnt;
    logic [3:0]  r_drain_cnt;
    logic        r_seq_err;

    logic [3:0]    w_nr;
    logic [4:0]    w_beats;
    logic [4:0]    w_beat_nxt;
    logic          w_accept;
    logic          w_any_start;
    logic          w_rd_last;
    logic [3:0]    w_rk_idx;
    logic [PW-1:0] w_pipe_in;
    logic [PW-1:0] w_pipe_out;
    logic          w_pipe_vld;

    assign w_nr        = nr_of(r_kl);
    assign w_beats     = {w_nr + 4'd1, 1'b0};
    assign w_beat_nxt  = r_beat_cnt + 5'd1;
    assign w_accept    = (r_state == ST_LOAD) && ld_valid;
    assign w_any_start = ld_start || rk_start;
    assign w_rd_last   = (r_rd_cnt == (r_dec ? 4'd0 : w_nr));
    assign w_rk_idx    = r_dec ? (w_nr - r_rd_cnt) : r_rd_cnt;

    always_ff @(posedge l2clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state     <= ST_IDLE;
            r_beat_cnt  <= '0;
            r_kl        <= KL_128;
            r_dec       <= 1'b0;
            r_rd_cnt    <= '0;
            r_drain_cnt <= '0;
            r_seq_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // ld_start has priority; a simultaneous rk_start is a protocol error.
                    if (ld_start) begin
                        if (rk_start || key_len == KL_RSV) r_seq_err <= 1'b1;
                        if (key_len != KL_RSV) begin
                            r_state    <= ST_LOAD;
                            r_beat_cnt <= '0;
                            r_kl       <= key_len;
                        end
                    end else if (rk_start) begin
                        if (key_len == KL_RSV) begin
                            r_seq_err <= 1'b1;
                        end else begin
                            r_state  <= ST_READ;
                            r_kl     <= key_len;
                            r_dec    <= rk_dec;
                            r_rd_cnt <= rk_dec ? nr_of(key_len) : 4'd0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_any_start) r_seq_err <= 1'b1;
                    if (w_accept) begin
                        r_beat_cnt <= w_beat_nxt;
                        if (ld_last) begin
                            r_state <= ST_IDLE;
                            if (w_beat_nxt != w_beats) r_seq_err <= 1'b1;
                        end else if (w_beat_nxt == w_beats) begin
                            // Full key without ld_last: stop so extra beats cannot overrun.
                            r_state   <= ST_IDLE;
                            r_seq_err <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (w_any_start) r_seq_err <= 1'b1;
                    if (w_rd_last) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= '0;
                    end else begin
                        r_rd_cnt <= r_dec ? (r_rd_cnt - 4'd1) : (r_rd_cnt + 4'd1);
                    end
                end
                default: begin
                    if (w_any_start) r_seq_err <= 1'b1;
                    if (r_drain_cnt == DRAIN_LAST) r_state <= ST_IDLE;
                    else                           r_drain_cnt <= r_drain_cnt + 4'd1;
                end
            endcase
        end
    end

    // Write port is driven only in LOAD and read port only in READ, so no collision.
    assign ld_ready  = (r_state == ST_LOAD);
    assign wr_enable = w_accept ? (r_beat_cnt[0] ? 2'b10 : 2'b01) : 2'b00;
    assign wr_addr   = w_accept ? r_beat_cnt[4:1] : 4'd0;
    assign wr_data   = w_accept ? ld_data : 64'd0;
    assign rd_enable = (r_state == ST_READ);
    assign rd_addr   = rd_enable ? r_rd_cnt : 4'd0;
    assign busy      = (r_state != ST_IDLE);
    assign seq_err   = r_seq_err;
    assign dbg_state = r_state;

`ifdef SPU_ARF_KEY_PARITY_EN
    logic r_par_lo [NENT];
    logic r_par_hi [NENT];

    always_ff @(posedge l2clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < NENT; i++) begin
                r_par_lo[i] <= 1'b0;
                r_par_hi[i] <= 1'b0;
            end
        end else if (w_accept) begin
            if (r_beat_cnt[0]) r_par_hi[r_beat_cnt[4:1]] <= ^ld_data;
            else               r_par_lo[r_beat_cnt[4:1]] <= ^ld_data;
        end
    end

    assign w_pipe_in = {r_par_hi[r_rd_cnt], r_par_lo[r_rd_cnt], w_rd_last, w_rk_idx};
    assign par_err   = w_pipe_vld &&
                       (((^arf_rd_data[63:0])   != w_pipe_out[5]) ||
                        ((^arf_rd_data[127:64]) != w_pipe_out[6]));
`else
    assign w_pipe_in = {w_rd_last, w_rk_idx};
`endif

    spu_arf_rd_pipe #(
        .RD_LAT (RD_LAT),
        .PW     (PW)
    ) u_rd_pipe (
        .i_clk   (l2clk),
        .i_rst_l (rst_l),
        .i_valid (rd_enable),
        .i_data  (w_pipe_in),
        .o_valid (w_pipe_vld),
        .o_data  (w_pipe_out)
    );

    assign rk_valid = w_pipe_vld;
    assign rk_idx   = w_pipe_vld ? w_pipe_out[3:0] : 4'd0;
    assign rk_done  = w_pipe_vld && w_pipe_out[4];

endmodule

// File: tb/tb_spu_arf_key_seq.sv
// Bench for spu_arf_key_seq: random key beats checked against a write scoreboard
// and round-key readout checked against a cycle timeline derived from the round count.
module tb_spu_arf_key_seq;

    localparam int RD_LAT = 1;

    logic        l2clk = 1'b0;
    logic        rst_l = 1'b0;
    logic [1:0]  key_len = 2'b00;
    logic        ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [63:0] ld_data = '0;
    logic        rk_start = 1'b0, rk_dec = 1'b0;
    logic        ld_ready, rk_valid, rk_done, rd_enable, busy, seq_err;
    logic [3:0]  rk_idx, wr_addr, rd_addr;
    logic [63:0] wr_data;
    logic [1:0]  wr_enable, dbg_state;
`ifdef SPU_ARF_KEY_PARITY_EN
    logic [127:0] arf_rd_data = '0;
    logic         par_err;
`endif

    int checks = 0;
    int failures = 0;
    logic [69:0] exp_q[$];

    always #5 l2clk = ~l2clk;

    spu_arf_key_seq #(.RD_LAT(RD_LAT)) dut (
        .l2clk     (l2clk),
        .rst_l     (rst_l),
        .key_len   (key_len),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .rk_start  (rk_start),
        .rk_dec    (rk_dec),
        .rk_valid  (rk_valid),
        .rk_idx    (rk_idx),
        .rk_done   (rk_done),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_enable (wr_enable),
        .rd_addr   (rd_addr),
        .rd_enable (rd_enable),
        .busy      (busy),
        .seq_err   (seq_err),
`ifdef SPU_ARF_KEY_PARITY_EN
        .arf_rd_data (arf_rd_data),
        .par_err     (par_err),
`endif
        .dbg_state (dbg_state)
    );

    function automatic int nr_tb(input logic [1:0] kl);
        return (kl == 2'b00) ? 10 : (kl == 2'b01) ? 12 : 14;
    endfunction

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ld_ready"}, 70'(ld_ready), 70'(0));
        check({tag, "_wr"}, {wr_addr, wr_enable, wr_data}, 70'(0));
        check({tag, "_rd"}, 70'({rd_enable, rd_addr}), 70'(0));
        check({tag, "_rk"}, 70'({rk_valid, rk_idx, rk_done}), 70'(0));
        check({tag, "_busy_state"}, 70'({busy, dbg_state}), 70'(0));
        check({tag, "_seq_err"}, 70'(seq_err), 70'(0));
    endtask

    task automatic clear_inputs();
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
        rk_start = 1'b0; rk_dec = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge l2clk);
        rst_l = 1'b0;
        clear_inputs();
        #1;
        check_quiet("reset");
        repeat (2) @(negedge l2clk);
        rst_l = 1'b1;
        exp_q.delete();
    endtask

    // Beat k is expected to write entry k/2, low half first; beats past `limit` must be dropped.
    task automatic do_load(input logic [1:0] kl, input int nbeats, input int last_at, input bit do_start);
        int limit;
        int gap;
        logic [63:0] d;
        logic [69:0] exp;
        limit = (last_at > 0) ? last_at : 2 * (nr_tb(kl) + 1);
        if (do_start) begin
            @(negedge l2clk);
            key_len = kl; ld_start = 1'b1;
            #1;
            check("start_ready", 70'(ld_ready), 70'(0));
        end
        for (int k = 0; k < nbeats; k++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge l2clk);
                ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
                #1;
                check("gap_ready", 70'(ld_ready), 70'(k < limit));
                check("gap_wr", 70'(wr_enable), 70'(0));
            end
            @(negedge l2clk);
            ld_start = 1'b0;
            d = {$urandom, $urandom};
            ld_valid = 1'b1; ld_data = d; ld_last = (k == last_at - 1);
            if (k < limit) exp_q.push_back({4'(k / 2), (k % 2 == 1) ? 2'b10 : 2'b01, d});
            #1;
            check("beat_ready", 70'(ld_ready), 70'(k < limit));
            check("beat_wr_fire", 70'(wr_enable != 2'b00), 70'(k < limit));
            check("beat_no_rd", 70'(rd_enable), 70'(0));
            if (wr_enable != 2'b00 && exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                check("beat_wr", {wr_addr, wr_enable, wr_data}, exp);
            end
        end
        @(negedge l2clk);
        clear_inputs();
        #1;
        check("load_end_busy", 70'({busy, dbg_state}), 70'(0));
        check("load_end_q", 70'(exp_q.size()), 70'(0));
    endtask

    // Cycle t after rk_start: issue on t=1..Nr+1, key valid RD_LAT cycles later.
    task automatic do_read(input logic [1:0] kl, input logic dec);
        int nr;
        int a, idx;
        bit e_rd, e_v;
        nr = nr_tb(kl);
        @(negedge l2clk);
        key_len = kl; rk_dec = dec; rk_start = 1'b1;
        #1;
        check("rd_start_idle", 70'(rd_enable), 70'(0));
        for (int t = 1; t <= nr + RD_LAT + 3; t++) begin
            @(negedge l2clk);
            rk_start = 1'b0; rk_dec = 1'b0;
            #1;
            e_rd = (t <= nr + 1);
            a    = e_rd ? (dec ? nr - (t - 1) : t - 1) : 0;
            e_v  = (t > RD_LAT) && (t <= nr + 1 + RD_LAT);
            idx  = e_v ? t - 1 - RD_LAT : 0;
            check("rd_enable", 70'(rd_enable), 70'(e_rd));
            check("rd_addr", 70'(rd_addr), 70'(a));
            check("rk_valid", 70'(rk_valid), 70'(e_v));
            check("rk_idx", 70'(rk_idx), 70'(idx));
            check("rk_done", 70'(rk_done), 70'(t == nr + 1 + RD_LAT));
            check("rd_busy", 70'(busy), 70'(t <= nr + 1 + RD_LAT));
            check("rd_no_wr", 70'({ld_ready, wr_enable}), 70'(0));
        end
        check("rd_seq_err", 70'(seq_err), 70'(0));
    endtask

    initial begin
        apply_reset();

        // AES-128 clean load then encrypt readout
        do_load(2'b00, 22, 22, 1'b1);
        check("l128_seq_err", 70'(seq_err), 70'(0));
        do_read(2'b00, 1'b0);

        // AES-256 load, encrypt readout
        do_load(2'b10, 30, 30, 1'b1);
        do_read(2'b10, 1'b0);

        // AES-192 load, decrypt readout
        do_load(2'b01, 26, 26, 1'b1);
        do_read(2'b01, 1'b1);

        // Reset during beat 7 of a load, then a clean load
        @(negedge l2clk);
        key_len = 2'b00; ld_start = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge l2clk);
            ld_start = 1'b0; ld_valid = 1'b1; ld_data = {$urandom, $urandom};
        end
        @(negedge l2clk);
        ld_data = {$urandom, $urandom};
        rst_l = 1'b0;
        #1;
        check_quiet("mid_load_reset");
        clear_inputs();
        repeat (2) @(negedge l2clk);
        rst_l = 1'b1;
        do_load(2'b00, 22, 22, 1'b1);
        check("post_reset_seq_err", 70'(seq_err), 70'(0));

        // Early ld_last on beat 20 of AES-128
        do_load(2'b00, 20, 20, 1'b1);
        check("early_last_err", 70'(seq_err), 70'(1));

        // ld_start and rk_start together: load wins, error flagged
        apply_reset();
        @(negedge l2clk);
        key_len = 2'b00; ld_start = 1'b1; rk_start = 1'b1; rk_dec = 1'b0;
        @(negedge l2clk);
        clear_inputs();
        #1;
        check("dual_start_state", 70'(dbg_state), 70'(1));
        check("dual_start_err", 70'(seq_err), 70'(1));
        check("dual_start_rd", 70'(rd_enable), 70'(0));
        do_load(2'b00, 22, 22, 1'b0);

        // Full AES-128 beat count without ld_last: beat 23 must be dropped
        apply_reset();
        do_load(2'b00, 23, 0, 1'b1);
        check("no_last_err", 70'(seq_err), 70'(1));

        // Reserved key length: no transition, error flagged
        apply_reset();
        @(negedge l2clk);
        key_len = 2'b11; ld_start = 1'b1;
        @(negedge l2clk);
        clear_inputs();
        #1;
        check("rsv_state", 70'({busy, dbg_state}), 70'(0));
        check("rsv_err", 70'(seq_err), 70'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
